// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcode classes, FSM states
// and load/store width codes.
package rv_ctrl_pkg;

    localparam logic [4:0] OpcOp     = 5'b01100;
    localparam logic [4:0] OpcOpImm  = 5'b00100;
    localparam logic [4:0] OpcLoad   = 5'b00000;
    localparam logic [4:0] OpcStore  = 5'b01000;
    localparam logic [4:0] OpcBranch = 5'b11000;
    localparam logic [4:0] OpcLui    = 5'b01101;
    localparam logic [4:0] OpcAuipc  = 5'b00101;
    localparam logic [4:0] OpcJal    = 5'b11011;
    localparam logic [4:0] OpcJalr   = 5'b11001;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    function automatic logic opcode_known(input logic [4:0] opc);
        logic known;
        case (opc)
            OpcOp, OpcOpImm, OpcLoad, OpcStore, OpcBranch,
            OpcLui, OpcAuipc, OpcJal, OpcJalr: known = 1'b1;
            default:                           known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/dm_mask_dec.sv
// Decodes load/store func3 into store byte enables and legality flags.
module dm_mask_dec
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] func3,
    output logic [3:0] w_en,
    output logic       store_ok,
    output logic       load_ok
);

    always_comb begin
        w_en     = 4'b0000;
        store_ok = 1'b1;
        case (func3)
            F3Byte:  w_en = 4'b0001;
            F3Half:  w_en = 4'b0011;
            F3Word:  w_en = 4'b1111;
            default: store_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (func3)
            F3Byte, F3Half, F3Word, F3ByteU, F3HalfU: load_ok = 1'b1;
            default:                                  load_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving a shared memory port,
// with cycle and retired-instruction counters.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             b,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_addr_sel,
    output logic             mem_we,
    output logic [3:0]       dm_w_en,
    output logic             ir_we,
    output logic             pc_we,
    output logic             next_pc_sel,
    output logic             jb_op1_sel,
    output logic             alu_op1_sel,
    output logic             alu_op2_sel,
    output logic             wb_en,
    output logic             wb_sel,
    output logic             instr_done,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_e           state_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] instret_cnt_q;

    logic is_load, is_store, is_branch, is_jal, is_jalr;
    logic sel_op1, sel_op2, sel_jb;
    logic store_ok, load_ok, legal;
    logic [3:0] store_mask;

    assign is_load   = (opcode == OpcLoad);
    assign is_store  = (opcode == OpcStore);
    assign is_branch = (opcode == OpcBranch);
    assign is_jal    = (opcode == OpcJal);
    assign is_jalr   = (opcode == OpcJalr);

    assign sel_op1 = (opcode == OpcAuipc) | is_jal | is_jalr;
    assign sel_op2 = (opcode == OpcOpImm) | is_load | is_store | (opcode == OpcLui)
                   | (opcode == OpcAuipc);
    assign sel_jb  = is_jal | is_branch;

    dm_mask_dec u_dm_mask_dec (
        .func3    (func3),
        .w_en     (store_mask),
        .store_ok (store_ok),
        .load_ok  (load_ok)
    );

    assign legal = opcode_known(opcode) && !(is_load && !load_ok) && !(is_store && !store_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle:   state_q <= StFetch;
                StFetch:  if (mem_ready) state_q <= StDecode;
                StDecode: state_q <= legal ? StExec : StTrap;
                StExec: begin
                    if (is_branch)                 state_q <= StFetch;
                    else if (is_load || is_store)  state_q <= StMem;
                    else                           state_q <= StWb;
                end
                StMem:    if (mem_ready) state_q <= is_store ? StFetch : StWb;
                StWb:     state_q <= StFetch;
                StTrap:   state_q <= StTrap;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Moore decode; only the ready-qualified pulses look at mem_ready.
    always_comb begin
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_we       = 1'b0;
        dm_w_en      = 4'b0000;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        next_pc_sel  = 1'b0;
        jb_op1_sel   = 1'b0;
        alu_op1_sel  = 1'b0;
        alu_op2_sel  = 1'b0;
        wb_en        = 1'b0;
        wb_sel       = 1'b0;
        instr_done   = 1'b0;
        trap         = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            StExec: begin
                alu_op1_sel = sel_op1;
                alu_op2_sel = sel_op2;
                jb_op1_sel  = sel_jb;
                if (is_branch) begin
                    pc_we       = 1'b1;
                    next_pc_sel = !b;
                    instr_done  = 1'b1;
                end
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                alu_op1_sel  = sel_op1;
                alu_op2_sel  = sel_op2;
                if (is_store) begin
                    mem_we  = 1'b1;
                    dm_w_en = store_mask;
                    if (mem_ready) begin
                        pc_we       = 1'b1;
                        next_pc_sel = 1'b1;
                        instr_done  = 1'b1;
                    end
                end
            end
            StWb: begin
                wb_en       = 1'b1;
                wb_sel      = is_load;
                pc_we       = 1'b1;
                next_pc_sel = !(is_jal || is_jalr);
                instr_done  = 1'b1;
            end
            StTrap:  trap = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != StIdle) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (instr_done)        instret_cnt_q <= instret_cnt_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl with a per-instruction scoreboard and
// hand-written trap/reset sequences.
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       opcode;
    logic [2:0]       func3;
    logic             b;
    logic             mem_ready;
    logic             mem_req, mem_addr_sel, mem_we, ir_we, pc_we, next_pc_sel;
    logic             jb_op1_sel, alu_op1_sel, alu_op2_sel, wb_en, wb_sel, instr_done, trap;
    logic [3:0]       dm_w_en;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .func3        (func3),
        .b            (b),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_addr_sel (mem_addr_sel),
        .mem_we       (mem_we),
        .dm_w_en      (dm_w_en),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .next_pc_sel  (next_pc_sel),
        .jb_op1_sel   (jb_op1_sel),
        .alu_op1_sel  (alu_op1_sel),
        .alu_op2_sel  (alu_op2_sel),
        .wb_en        (wb_en),
        .wb_sel       (wb_sel),
        .instr_done   (instr_done),
        .trap         (trap),
        .state        (state),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] op;
        logic [2:0] f3;
        logic       b;
        int         fw;      // FETCH wait cycles
        int         mw;      // MEM wait cycles
        int         cyc;     // expected cycles to retire
        logic       wb;      // WB state visited / wb_en pulse
        logic       wb_sel;
        logic       npc;     // next_pc_sel at pc_we
        logic       jb;      // jb_op1_sel in EXEC
        logic [3:0] mask;
        logic       op1;
        logic       op2;
        int         maddr;   // cycles with mem_addr_sel=1
    } vec_t;

    typedef struct {
        vec_t v;
        int   cum;
        int   seq;
    } sb_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];
    sb_t  sbq[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   cum = 0;
    int   nret = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        sb_t        e;
        int         i;
        logic       done, load_ir, saw_wb, wbsel, npc, jb, op1, op2;
        int         nmaddr, npcwe, nwben;
        logic [3:0] mask;
        logic [31:0] cc, ic;
        cum += v.cyc;
        nret++;
        e.v = v; e.cum = cum; e.seq = nret;
        sbq.push_back(e);
        b = v.b;
        done = 1'b0; saw_wb = 1'b0; wbsel = 1'b0; npc = 1'b0; jb = 1'b0; op1 = 1'b0;
        op2 = 1'b0; nmaddr = 0; npcwe = 0; nwben = 0; mask = 4'b0000; cc = '0; ic = '0;
        for (i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            mem_ready = !((i < v.fw) || (i >= v.fw + 3 && i < v.fw + 3 + v.mw));
            #1;
            if (mem_addr_sel) nmaddr++;
            if (pc_we) begin npcwe++; npc = next_pc_sel; end
            if (wb_en) begin nwben++; wbsel = wb_sel; end
            if (state == 3'd5) saw_wb = 1'b1;
            if (state == 3'd3) begin op1 = alu_op1_sel; op2 = alu_op2_sel; jb = jb_op1_sel; end
            mask    = mask | dm_w_en;
            load_ir = ir_we;
            if (instr_done) begin
                done = 1'b1;
                cc   = cycle_cnt;
                ic   = instret_cnt;
            end else begin
                @(posedge clk);
                if (load_ir) begin
                    #1;
                    opcode = v.op;
                    func3  = v.f3;
                end
            end
        end
        e = sbq.pop_front();
        if (!done) begin
            n_vec++;
            n_mis++;
            $display("FAIL vec%0d_timeout: got no instr_done expected retire in %0d", id, e.v.cyc);
        end
        check($sformatf("vec%0d_cycles", id), i, e.v.cyc);
        check($sformatf("vec%0d_wb_en", id), nwben, {31'd0, e.v.wb});
        check($sformatf("vec%0d_wb_state", id), {31'd0, saw_wb}, {31'd0, e.v.wb});
        check($sformatf("vec%0d_wb_sel", id), {31'd0, wbsel}, {31'd0, e.v.wb_sel});
        check($sformatf("vec%0d_pc_we", id), npcwe, 1);
        check($sformatf("vec%0d_next_pc_sel", id), {31'd0, npc}, {31'd0, e.v.npc});
        check($sformatf("vec%0d_jb_op1", id), {31'd0, jb}, {31'd0, e.v.jb});
        check($sformatf("vec%0d_alu_sel", id), {30'd0, op1, op2}, {30'd0, e.v.op1, e.v.op2});
        check($sformatf("vec%0d_dm_w_en", id), {28'd0, mask}, {28'd0, e.v.mask});
        check($sformatf("vec%0d_addr_sel", id), nmaddr, e.v.maddr);
        check($sformatf("vec%0d_cycle_cnt", id), cc, e.cum - 1);
        check($sformatf("vec%0d_instret", id), ic, e.seq - 1);
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_state"}, {29'd0, state}, 0);
        check({tag, "_rst_req"}, {31'd0, mem_req}, 0);
        check({tag, "_rst_trap"}, {31'd0, trap}, 0);
        check({tag, "_rst_cnt"}, cycle_cnt | instret_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_fetch_after_release"}, {29'd0, state}, 1);
        check({tag, "_cnt_after_release"}, cycle_cnt, 0);
        cum  = 0;
        nret = 0;
    endtask

    task automatic run_trap(input logic [4:0] op, input logic [2:0] f3, input string tag);
        logic [31:0] c0;
        logic        anyout, alltrap;
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check({tag, "_ir_we"}, {31'd0, ir_we}, 1);
        @(posedge clk);
        #1;
        opcode = op;
        func3  = f3;
        @(negedge clk);
        #1;
        check({tag, "_decode"}, {29'd0, state}, 2);
        @(negedge clk);
        #1;
        check({tag, "_enter"}, {29'd0, state}, 6);
        c0 = cycle_cnt;
        anyout = 1'b0;
        alltrap = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            anyout  = anyout | mem_req | mem_we | ir_we | pc_we | wb_en | instr_done
                    | (|dm_w_en) | mem_addr_sel | next_pc_sel;
            alltrap = alltrap & trap;
        end
        check({tag, "_quiet"}, {31'd0, anyout}, 0);
        check({tag, "_held"}, {31'd0, alltrap}, 1);
        check({tag, "_cycle_cnt"}, cycle_cnt, c0 + 12);
        do_reset(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        //          op        f3     b     fw mw cyc wb    wbs   npc   jb    mask     op1   op2  ma
        vecs[0]  = '{5'b01100, 3'b000, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 0};
        vecs[1]  = '{5'b00100, 3'b000, 1'b0, 1, 0, 5, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 0};
        vecs[2]  = '{5'b00000, 3'b010, 1'b0, 0, 2, 7, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 3};
        vecs[3]  = '{5'b01000, 3'b001, 1'b0, 0, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b1, 1};
        vecs[4]  = '{5'b11000, 3'b000, 1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 0};
        vecs[5]  = '{5'b11000, 3'b000, 1'b0, 0, 0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 0};
        vecs[6]  = '{5'b01101, 3'b000, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 0};
        vecs[7]  = '{5'b00101, 3'b000, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 0};
        vecs[8]  = '{5'b11011, 3'b000, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 0};
        vecs[9]  = '{5'b11001, 3'b000, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 0};
        vecs[10] = '{5'b01000, 3'b000, 1'b0, 1, 1, 6, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2};
        vecs[11] = '{5'b01000, 3'b010, 1'b0, 0, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 1};
        vecs[12] = '{5'b00000, 3'b101, 1'b0, 2, 0, 7, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1};
        vecs[13] = '{5'b11000, 3'b001, 1'b1, 0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 0};

        rst_n = 1'b0;
        opcode = 5'b00000;
        func3 = 3'b000;
        b = 1'b0;
        mem_ready = 1'b0;
        #12;
        check("reset_state", {29'd0, state}, 0);
        check("reset_outputs", {15'd0, mem_req, mem_addr_sel, mem_we, dm_w_en, ir_we, pc_we,
               next_pc_sel, jb_op1_sel, alu_op1_sel, alu_op2_sel, wb_en, wb_sel, instr_done,
               trap}, 0);
        check("reset_counters", cycle_cnt | instret_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_exit", {29'd0, state}, 1);

        for (int n = 0; n < NVEC; n++) run_vec(vecs[n], n);

        run_trap(5'b11111, 3'b000, "trap_opc");
        run_vec(vecs[0], 100);
        run_trap(5'b01000, 3'b011, "trap_st");
        run_vec(vecs[2], 101);

        // Reset while FETCH is stalled waiting on mem_ready.
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("midfetch_req", {31'd0, mem_req}, 1);
        check("midfetch_cnt", cycle_cnt, cum);
        do_reset("midfetch");
        run_vec(vecs[3], 102);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
